// File: rtl/branch_snapshot_stack_pkg.sv
// branch_snapshot_stack_pkg: shared sizes, entry types and retire-mask helper for the branch snapshot stack
package branch_snapshot_stack_pkg;
  localparam int DEPTH = 4;
  localparam int PR_SZ = 64;
  localparam int N = 2;
  localparam int PR_IDX = $clog2(PR_SZ);
  localparam int NUM_BITS = $clog2(N + 1);
  typedef logic [DEPTH-1:0] branch_mask_t;
  typedef logic [PR_SZ-1:0] free_list_t;
  typedef logic [N-1:0][PR_IDX-1:0] retire_regs_t;
  typedef struct packed {
    logic         valid;
    branch_mask_t tag;
    branch_mask_t dep_mask;
    free_list_t   snap;
  } branch_stack_entry_t;
  // only the low-index num entries of regs are live
  function automatic free_list_t retire_vec(input retire_regs_t regs, input logic [NUM_BITS-1:0] num);
    retire_vec = '0;
    for (int i = 0; i < N; i++)
      if (i < int'(num)) retire_vec[regs[i]] = 1'b1;
  endfunction
endpackage

// File: rtl/branch_snapshot_stack_if.sv
// branch_snapshot_stack_if: dispatch/resolve/retire bus of the branch snapshot stack
// master = dispatch/execute/retire side, slave = the stack
// Optional BRANCH_STACK_STATS_EN adds stat_mispredicts / stat_full_cycles.
interface branch_snapshot_stack_if;
  import branch_snapshot_stack_pkg::*;
  logic                alloc_valid;
  free_list_t          alloc_free_list;
  branch_mask_t        alloc_tag;
  logic                full;
  branch_mask_t        branch_mask;
  retire_regs_t        phys_regs_retiring;
  logic [NUM_BITS-1:0] num_retiring_valid;
  logic                resolve_valid;
  branch_mask_t        resolve_tag;
  logic                resolve_mispredict;
  logic                restore_flag;
  free_list_t          free_list_restore;
  branch_mask_t        squash_mask;
`ifdef BRANCH_STACK_STATS_EN
  logic [31:0]         stat_mispredicts;
  logic [31:0]         stat_full_cycles;
  modport master(output alloc_valid, alloc_free_list, phys_regs_retiring, num_retiring_valid,
                 resolve_valid, resolve_tag, resolve_mispredict,
                 input alloc_tag, full, branch_mask, restore_flag, free_list_restore, squash_mask,
                 stat_mispredicts, stat_full_cycles);
  modport slave(input alloc_valid, alloc_free_list, phys_regs_retiring, num_retiring_valid,
                resolve_valid, resolve_tag, resolve_mispredict,
                output alloc_tag, full, branch_mask, restore_flag, free_list_restore, squash_mask,
                stat_mispredicts, stat_full_cycles);
`else
  modport master(output alloc_valid, alloc_free_list, phys_regs_retiring, num_retiring_valid,
                 resolve_valid, resolve_tag, resolve_mispredict,
                 input alloc_tag, full, branch_mask, restore_flag, free_list_restore, squash_mask);
  modport slave(input alloc_valid, alloc_free_list, phys_regs_retiring, num_retiring_valid,
                resolve_valid, resolve_tag, resolve_mispredict,
                output alloc_tag, full, branch_mask, restore_flag, free_list_restore, squash_mask);
`endif
endinterface

// File: rtl/branch_snapshot_stack_psel_gen.sv
// branch_snapshot_stack_psel_gen: priority selector granting up to REQS lowest-index requests
// i_req: request vector; o_gnt: REQS one-hot grants packed low grant first
module branch_snapshot_stack_psel_gen #(
  parameter int WIDTH = 4,
  parameter int REQS = 1
) (
  input  logic [WIDTH-1:0]      i_req,
  output logic [REQS*WIDTH-1:0] o_gnt
);
  logic [WIDTH-1:0] w_rem [REQS+1];
  assign w_rem[0] = i_req;
  for (genvar g = 0; g < REQS; g++) begin : g_sel
    logic [WIDTH-1:0] w_g;
    assign w_g = w_rem[g] & (-w_rem[g]);
    assign o_gnt[g*WIDTH +: WIDTH] = w_g;
    assign w_rem[g+1] = w_rem[g] & ~w_g;
  end
endmodule

// File: rtl/branch_snapshot_stack.sv
// branch_snapshot_stack: in-flight branch tracker holding a free-list snapshot per branch
// i_clock, i_reset_n (sync active-low); bus: slave side of branch_snapshot_stack_if
// Optional BRANCH_STACK_STATS_EN adds saturating mispredict / full-stall counters.
module branch_snapshot_stack
  import branch_snapshot_stack_pkg::*;
(
  input logic                    i_clock,
  input logic                    i_reset_n,
  branch_snapshot_stack_if.slave bus
);
  branch_stack_entry_t r_ent [DEPTH];
  branch_stack_entry_t w_nxt [DEPTH];
  branch_mask_t w_valid, w_grant, w_sq, w_cor_tag, r_sq;
  free_list_t w_ret, w_snap_res, r_restore;
  logic w_res_ok, w_mis, w_cor, w_full, w_alloc, r_flag;
  branch_snapshot_stack_psel_gen #(.WIDTH(DEPTH), .REQS(1)) u_psel (
    .i_req(~w_valid),
    .o_gnt(w_grant)
  );
  always_comb begin
    w_valid = '0;
    for (int i = 0; i < DEPTH; i++) w_valid[i] = r_ent[i].valid;
  end
  // resolves naming an empty slot or several slots are dropped
  assign w_res_ok = bus.resolve_valid & $onehot(bus.resolve_tag) & |(bus.resolve_tag & w_valid);
  assign w_mis = w_res_ok & bus.resolve_mispredict;
  assign w_cor = w_res_ok & ~bus.resolve_mispredict;
  assign w_cor_tag = w_cor ? bus.resolve_tag : '0;
  assign w_full = &w_valid | r_flag;
  assign w_alloc = bus.alloc_valid & ~w_full & ~w_mis;
  assign w_ret = retire_vec(bus.phys_regs_retiring, bus.num_retiring_valid);
  always_comb begin
    w_sq = '0;
    w_snap_res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sq[i] = w_mis & r_ent[i].valid & (r_ent[i].tag == bus.resolve_tag || |(r_ent[i].dep_mask & bus.resolve_tag));
      w_snap_res = w_snap_res | ((r_ent[i].valid && r_ent[i].tag == bus.resolve_tag) ? r_ent[i].snap : '0);
    end
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = r_ent[i];
      w_nxt[i].snap = r_ent[i].snap | w_ret;
      w_nxt[i].dep_mask = r_ent[i].dep_mask & ~w_cor_tag;
      w_nxt[i].valid = r_ent[i].valid & ~w_sq[i] & ~|(r_ent[i].tag & w_cor_tag);
      if (w_alloc && w_grant[i])
        w_nxt[i] = '{valid: 1'b1, tag: branch_mask_t'(1 << i), dep_mask: w_valid & ~w_cor_tag,
                     snap: bus.alloc_free_list | w_ret};
    end
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_flag <= 1'b0;
      r_restore <= '0;
      r_sq <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_nxt[i];
      r_flag <= w_mis;
      r_restore <= w_mis ? (w_snap_res | w_ret) : '0;
      r_sq <= w_sq;
    end
  end
  assign bus.alloc_tag = w_alloc ? w_grant : '0;
  assign bus.full = w_full;
  assign bus.branch_mask = w_valid;
  assign bus.restore_flag = r_flag;
  assign bus.free_list_restore = r_restore;
  assign bus.squash_mask = r_sq;
`ifdef BRANCH_STACK_STATS_EN
  logic [31:0] r_stat_mis, r_stat_full;
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_stat_mis <= '0;
      r_stat_full <= '0;
    end else begin
      r_stat_mis <= r_stat_mis + {31'b0, w_mis & ~&r_stat_mis};
      r_stat_full <= r_stat_full + {31'b0, bus.alloc_valid & w_full & ~&r_stat_full};
    end
  end
  assign bus.stat_mispredicts = r_stat_mis;
  assign bus.stat_full_cycles = r_stat_full;
`endif
  a_resolve_onehot: assert property (@(posedge i_clock) disable iff (!i_reset_n)
    bus.resolve_valid |-> $onehot(bus.resolve_tag));
endmodule

// File: tb/tb_branch_snapshot_stack.sv
// tb_branch_snapshot_stack: table-driven directed bench for branch_snapshot_stack
module tb_branch_snapshot_stack;
  import branch_snapshot_stack_pkg::*;
  typedef struct {
    logic av; logic [63:0] fl; logic rv; logic [3:0] rt; logic rm;
    logic [1:0] num; logic [5:0] r0; logic [5:0] r1;
    logic [3:0] etag; logic efull; logic [3:0] ebm; logic erf; logic [63:0] eflr; logic [3:0] esq;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t vt [22];
  branch_snapshot_stack_if bus();
  branch_snapshot_stack dut (.i_clock(clk), .i_reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic av, logic [63:0] fl, logic rv, logic [3:0] rt, logic rm,
                              logic [1:0] num, logic [5:0] r0, logic [5:0] r1, logic [3:0] etag,
                              logic efull, logic [3:0] ebm, logic erf, logic [63:0] eflr, logic [3:0] esq);
    mk = '{av, fl, rv, rt, rm, num, r0, r1, etag, efull, ebm, erf, eflr, esq};
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic drive(vec_t v);
    bus.alloc_valid = v.av;
    bus.alloc_free_list = v.fl;
    bus.resolve_valid = v.rv;
    bus.resolve_tag = v.rt;
    bus.resolve_mispredict = v.rm;
    bus.num_retiring_valid = v.num;
    bus.phys_regs_retiring[0] = v.r0;
    bus.phys_regs_retiring[1] = v.r1;
  endtask
  initial begin
    vt[0]  = mk(1, 64'h1,  0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 64'h0, 4'b0000);
    vt[1]  = mk(1, 64'h2,  0, 4'b0000, 0, 0, 0, 0, 4'b0010, 0, 4'b0011, 0, 64'h0, 4'b0000);
    vt[2]  = mk(1, 64'h4,  0, 4'b0000, 0, 0, 0, 0, 4'b0100, 0, 4'b0111, 0, 64'h0, 4'b0000);
    vt[3]  = mk(1, 64'h8,  0, 4'b0000, 0, 0, 0, 0, 4'b1000, 0, 4'b1111, 0, 64'h0, 4'b0000);
    vt[4]  = mk(1, 64'h10, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 4'b1111, 0, 64'h0, 4'b0000);
    vt[5]  = mk(0, 64'h0,  1, 4'b0001, 0, 0, 0, 0, 4'b0000, 1, 4'b1110, 0, 64'h0, 4'b0000);
    vt[6]  = mk(0, 64'h0,  1, 4'b0010, 1, 0, 0, 0, 4'b0000, 0, 4'b0000, 1, 64'h2, 4'b1110);
    vt[7]  = mk(1, 64'h5,  0, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 64'h0, 4'b0000);
    vt[8]  = mk(1, 64'hFFFF000000000000, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 64'h0, 4'b0000);
    vt[9]  = mk(0, 64'h0,  0, 4'b0000, 0, 2, 5, 9, 4'b0000, 0, 4'b0001, 0, 64'h0, 4'b0000);
    vt[10] = mk(0, 64'h0,  1, 4'b0001, 1, 1, 1, 63, 4'b0000, 0, 4'b0000, 1, 64'hFFFF000000000222, 4'b0001);
    vt[11] = mk(1, 64'h7,  0, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 64'h0, 4'b0000);
    vt[12] = mk(1, 64'hA,  0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 64'h0, 4'b0000);
    vt[13] = mk(1, 64'hB,  0, 4'b0000, 0, 0, 0, 0, 4'b0010, 0, 4'b0011, 0, 64'h0, 4'b0000);
    vt[14] = mk(1, 64'hC,  0, 4'b0000, 0, 0, 0, 0, 4'b0100, 0, 4'b0111, 0, 64'h0, 4'b0000);
    vt[15] = mk(1, 64'hD,  1, 4'b0001, 1, 0, 0, 0, 4'b0000, 0, 4'b0000, 1, 64'hA, 4'b0111);
    vt[16] = mk(0, 64'h0,  0, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 64'h0, 4'b0000);
    vt[17] = mk(1, 64'h11, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 64'h0, 4'b0000);
    vt[18] = mk(1, 64'h12, 0, 4'b0000, 0, 0, 0, 0, 4'b0010, 0, 4'b0011, 0, 64'h0, 4'b0000);
    vt[19] = mk(1, 64'h13, 0, 4'b0000, 0, 0, 0, 0, 4'b0100, 0, 4'b0111, 0, 64'h0, 4'b0000);
    vt[20] = mk(1, 64'h14, 1, 4'b0010, 0, 0, 0, 0, 4'b1000, 0, 4'b1101, 0, 64'h0, 4'b0000);
    vt[21] = mk(0, 64'h0,  1, 4'b0100, 1, 0, 0, 0, 4'b0000, 0, 4'b0001, 1, 64'h13, 4'b1100);
    drive(vt[16]);
    repeat (2) @(posedge clk);
    #1;
    chk("reset branch_mask", 64'(bus.branch_mask), 64'h0);
    chk("reset restore_flag", 64'(bus.restore_flag), 64'h0);
    chk("reset squash_mask", 64'(bus.squash_mask), 64'h0);
    chk("reset free_list_restore", bus.free_list_restore, 64'h0);
    rst_n = 1'b1;
    #1;
    chk("reset full", 64'(bus.full), 64'h0);
    for (int i = 0; i < 22; i++) begin
      drive(vt[i]);
      #1;
      chk($sformatf("v%0d alloc_tag", i), 64'(bus.alloc_tag), 64'(vt[i].etag));
      chk($sformatf("v%0d full", i), 64'(bus.full), 64'(vt[i].efull));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d branch_mask", i), 64'(bus.branch_mask), 64'(vt[i].ebm));
      chk($sformatf("v%0d restore_flag", i), 64'(bus.restore_flag), 64'(vt[i].erf));
      chk($sformatf("v%0d free_list_restore", i), bus.free_list_restore, vt[i].eflr);
      chk($sformatf("v%0d squash_mask", i), 64'(bus.squash_mask), 64'(vt[i].esq));
    end
    drive(vt[16]);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrestore restore_flag", 64'(bus.restore_flag), 64'h0);
    chk("midrestore free_list_restore", bus.free_list_restore, 64'h0);
    chk("midrestore squash_mask", 64'(bus.squash_mask), 64'h0);
    chk("midrestore branch_mask", 64'(bus.branch_mask), 64'h0);
    chk("midrestore full", 64'(bus.full), 64'h0);
    rst_n = 1'b1;
    drive(vt[0]);
    #1;
    chk("post reset alloc_tag", 64'(bus.alloc_tag), 64'h1);
    @(posedge clk);
    #1;
    chk("post reset branch_mask", 64'(bus.branch_mask), 64'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
